// File: rtl/ladybird_uart_loader.sv
// ladybird_uart_loader: receives a length-prefixed image over UART RX and
// writes it word-by-word onto the instruction bus. `done` releases the core.
module ladybird_uart_loader #(
  parameter logic [15:0] WTIME     = 16'h364,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_ERR} ld_state_t;

  localparam logic [1:0] E_FRAME   = 2'b01;
  localparam logic [1:0] E_OVERRUN = 2'b10;
  localparam logic [1:0] E_LENGTH  = 2'b11;

  // Saturating word counter increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  // ---------------- RX line synchroniser ----------------
  logic rxd_p0, rxd_p1, rxd_p2;
  logic rx_fall;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= uart_rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  assign rx_fall = rxd_p2 & ~rxd_p1;

  // ---------------- RX byte FSM ----------------
  rx_state_t   rx_state, rx_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  bitn, bitn_next;
  logic [7:0]  sh, sh_next;
  logic        byte_valid, frame_err, expire;

  assign expire = (cnt <= 16'd1);

  // RX state and bit-timing registers; the shift register carries data only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= R_IDLE;
      cnt      <= 16'd0;
      bitn     <= 3'd0;
    end else begin
      rx_state <= rx_next;
      cnt      <= cnt_next;
      bitn     <= bitn_next;
    end
    sh <= sh_next;
  end

  // RX next-state: start-bit qualification at mid-bit, 8 data bits LSB first, stop check.
  always_comb begin
    rx_next    = rx_state;
    cnt_next   = cnt;
    bitn_next  = bitn;
    sh_next    = sh;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (rx_fall) begin
          rx_next  = R_START;
          cnt_next = WTIME >> 1;
        end
      end
      R_START: begin
        if (expire) begin
          if (!rxd_p1) begin
            rx_next   = R_DATA;
            cnt_next  = WTIME;
            bitn_next = 3'd0;
          end else begin
            rx_next = R_IDLE;
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      R_DATA: begin
        if (expire) begin
          sh_next  = {rxd_p1, sh[7:1]};
          cnt_next = WTIME;
          if (bitn == 3'd7) rx_next = R_STOP;
          else              bitn_next = bitn + 3'd1;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      R_STOP: begin
        if (expire) begin
          if (rxd_p1) byte_valid = 1'b1;
          else        frame_err  = 1'b1;
          rx_next = R_IDLE;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      default: rx_next = R_IDLE;
    endcase
  end

  // ---------------- Loader FSM and bus master ----------------
  ld_state_t   ld_state, ld_next;
  logic [1:0]  byte_idx, idx_next;
  logic [23:0] asm_word, asm_next;
  logic [31:0] len, len_next;
  logic [31:0] hold, hold_next;
  logic        req, req_next;
  logic [15:0] wc, wc_next;
  logic [1:0]  ecode, ecode_next;
  logic [31:0] word_in;
  logic        granted, last_word;

  assign word_in   = {sh, asm_word};
  assign granted   = req && bus_gnt;
  assign last_word = granted && ({16'd0, sat_inc16(wc)} == len);

  // Loader control registers reset; assembled/held words are pure data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state <= L_LEN;
      byte_idx <= 2'd0;
      req      <= 1'b0;
      wc       <= 16'd0;
      ecode    <= 2'b00;
    end else begin
      ld_state <= ld_next;
      byte_idx <= idx_next;
      req      <= req_next;
      wc       <= wc_next;
      ecode    <= ecode_next;
    end
    asm_word <= asm_next;
    len      <= len_next;
    hold     <= hold_next;
  end

  // Loader next-state: length capture, word assembly, handshake, overrun and error handling.
  always_comb begin
    ld_next    = ld_state;
    idx_next   = byte_idx;
    asm_next   = asm_word;
    len_next   = len;
    hold_next  = hold;
    req_next   = req;
    wc_next    = wc;
    ecode_next = ecode;
    case (ld_state)
      L_LEN: begin
        if (frame_err) begin
          ld_next    = L_ERR;
          ecode_next = E_FRAME;
        end else if (byte_valid) begin
          asm_next = word_in[31:8];
          idx_next = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            if (word_in == 32'd0) begin
              ld_next = L_DONE;
            end else if (word_in > MAX_WORDS) begin
              ld_next    = L_ERR;
              ecode_next = E_LENGTH;
            end else begin
              ld_next  = L_DATA;
              len_next = word_in;
            end
          end
        end
      end
      L_DATA: begin
        if (granted) begin
          req_next = 1'b0;
          wc_next  = sat_inc16(wc);
          if (last_word) ld_next = L_DONE;
        end
        if (frame_err) begin
          ld_next    = L_ERR;
          ecode_next = E_FRAME;
          req_next   = 1'b0;
        end else if (byte_valid && !last_word) begin
          asm_next = word_in[31:8];
          idx_next = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            if (req && !bus_gnt) begin
              // Previous word still waiting: drop the new one and withdraw the request.
              ld_next    = L_ERR;
              ecode_next = E_OVERRUN;
              req_next   = 1'b0;
            end else begin
              hold_next = word_in;
              req_next  = 1'b1;
            end
          end
        end
      end
      L_DONE:  req_next = 1'b0;
      L_ERR:   req_next = 1'b0;
      default: ld_next = L_ERR;
    endcase
  end

  // Address follows the committed count, which only moves when a request completes.
  assign bus_req    = req;
  assign bus_wstrb  = req ? 4'hf : 4'h0;
  assign bus_addr   = req ? (BASE_ADDR + {14'd0, wc, 2'b00}) : 32'd0;
  assign bus_data   = req ? hold : 32'd0;
  assign busy       = (ld_state == L_DATA);
  assign done       = (ld_state == L_DONE);
  assign err        = (ld_state == L_ERR);
  assign err_code   = ecode;
  assign word_count = wc;

endmodule

// File: doc/ladybird_uart_loader.md
Name: ladybird_uart_loader

Overview:
Host-side program loader. Receives a length-prefixed binary image over UART RX and writes it word-by-word into instruction RAM. It acts as a master on the instruction bus and sits directly upstream of the instruction-bus arbitrator, next to the core ibus port. `done` is used to release the core from reset once the image is in place.

Parameters:
WTIME, 16'h364, clock cycles per UART bit (16 bits wide; must be at least 4).
BASE_ADDR, 32'h0000_0000, byte address of the first word written.
MAX_WORDS, 1024, largest accepted word count; larger lengths are an error.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
uart_rxd  input  1  UART receive line, asynchronous, idle high
bus_req  output  1  write request to the instruction-bus arbitrator
bus_gnt  input  1  grant; transfer completes on a posedge where bus_req && bus_gnt
bus_addr  output  32  byte address, word aligned
bus_wstrb  output  4  byte strobes; 4'hf during a request, 4'h0 otherwise
bus_data  output  32  write data
busy  output  1  a load is in progress (length received, not yet finished)
done  output  1  all words written; sticky until rst
err  output  1  loader halted on an error; sticky until rst
err_code  output  2  00 none, 01 framing, 10 overrun, 11 length
word_count  output  16  number of words committed to the bus so far

Behaviour:
- Reset (rst=1 at posedge): every output is 0, all FSMs return to idle, and any partial byte or word is discarded. Reset mid-transfer drops bus_req on the next cycle; the grant is not awaited.
- RX synchroniser: uart_rxd passes through 2 flops before use. Its reset value is 1.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE to R_START on a synchronised falling edge; the bit counter loads WTIME/2.
  - R_START: when the counter expires, sample the line. If low, go to R_DATA with the counter at WTIME. If high (glitch), return to R_IDLE with no error.
  - R_DATA: sample 8 bits LSB-first, one every WTIME cycles, then go to R_STOP.
  - R_STOP: sample after WTIME. If high, emit a 1-cycle byte_valid and return to R_IDLE. If low, raise a framing error.
- Frame format: 4 bytes little-endian length N (in words), then N words, each 4 bytes little-endian.
- Word k (0-based) is written to BASE_ADDR + 4*k.
- Loader FSM states: L_LEN, L_DATA, L_DONE, L_ERR.
  - L_LEN: assemble the 4 length bytes.
    - N == 0: go to L_DONE; done rises 1 cycle after the 4th byte_valid.
    - N > MAX_WORDS: go to L_ERR with code 11.
    - Otherwise: go to L_DATA and set busy=1.
  - L_DATA: each 4th byte loads the one-word holding register and marks a write pending.
  - L_DONE: busy=0, done=1; further RX bytes are ignored.
  - L_ERR: busy=0, err=1, err_code held, bus_req=0; further RX bytes are ignored; the state persists until rst.
- Bus handshake:
  - bus_req rises the cycle after the holding register loads.
  - bus_addr, bus_wstrb and bus_data are stable while bus_req=1.
  - On a posedge with bus_req && bus_gnt: bus_req falls the next cycle and word_count increments.
  - When word_count reaches N: go to L_DONE (done=1) in the same cycle bus_req falls.
- Overrun: if a 4th data byte completes while the previous write is still pending, the new word is dropped and the loader goes to L_ERR with code 10. The pending request is withdrawn the next cycle.
- Framing error: in any L state other than L_DONE and L_ERR, go to L_ERR with code 01. A partial word is discarded.
- Simultaneous byte_valid and grant in one cycle: both take effect; the grant completes the old word and the byte is assembled.
- word_count saturates at 16'hffff; this is unreachable when MAX_WORDS is 1024.

Test Plan:
1. WTIME=16. Send length 5, then words 0xfff00093, 0x00008103, 0x00110113, 0x00208023, 0xff5ff06f, with bus_gnt tied to 1 → five 1-cycle requests at addresses 0x0, 0x4, 0x8, 0xc, 0x10 with matching data and wstrb=4'hf; word_count=5; done=1; busy=0.
2. Same image with bus_gnt held low for 20 cycles per request → request, address and data stay stable until the grant; final memory contents are identical; err=0.
3. bus_gnt held low forever, send length 2 and two words → after the 8th data byte, err=1, err_code=10, bus_req=0, word_count=0.
4. Stop bit driven low on the 2nd length byte → err=1, err_code=01, no bus_req ever asserted; a later valid frame is ignored.
5. Length 0x00000401 with MAX_WORDS=1024 → err_code=11 right after the 4th byte. Length 0 → done=1 and no bus activity.
6. rst pulsed mid-word during the 2nd data word → all outputs 0 the next cycle; resending the full frame then loads correctly with word_count=N.
